// File: rtl/xbus_pkg.sv
// Shared constants for the external-bus master: FSM state encoding,
// wait-counter width and chip-select field helpers.
package xbus_pkg;

  // Bus-cycle sequencer states (registered encoding, 3 bits).
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ADDR   = 3'd1;
  localparam logic [2:0] SETUP  = 3'd2;
  localparam logic [2:0] STROBE = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;

  // Wait-state counter width; covers WAIT_CYC values 0..15.
  localparam int WAIT_CNT_W = 4;

  // Legal range of decoded top-address bits.
  localparam int CS_BITS_MIN = 1;
  localparam int CS_BITS_MAX = 4;

  // Number of chip-select lines produced from cs_bits address bits.
  function automatic int cs_lines(input int cs_bits);
    return 1 << cs_bits;
  endfunction

endpackage

// File: rtl/xbus_cs_decode.sv
// Registered active-low chip-select decoder (CS_BITS in, 2**CS_BITS out).
// Successor of the board's discrete 3-to-8 decoder; all lines idle high.
module xbus_cs_decode
  import xbus_pkg::*;
#(
  parameter int CS_BITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [CS_BITS-1:0]      sel,
  output logic [(2**CS_BITS)-1:0] cs_n
);

  // One line low while enabled; all lines high otherwise or in reset.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cs_n <= '1;
    end else begin
      cs_n      <= '1;
      cs_n[sel] <= 1'b0;
    end
  end

endmodule

// File: rtl/xbus_master.sv
// External multiplexed address/data bus master sequencer.
// Runs one single-beat read or write per request: ADDR (ale), SETUP (cs,
// data drive or turnaround), STROBE (oe_n/we_n, WAIT_CYC+1 cycles), HOLD.
// All bus outputs are registered so the pins never glitch.
// Optional macro XBUS_READY_EN adds ext_ready, which stretches STROBE
// after the programmed wait states until the target signals ready.
//
// Request handshake: a request transfers on a rising edge where both
// req_valid and req_ready are high; req_ready is high only in IDLE and
// outside reset, and req_* are ignored at any other time. The response
// side has no back-pressure: rsp_valid is a single-cycle pulse.
module xbus_master
  import xbus_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int CS_BITS  = 3,
  parameter int WAIT_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic [ADDR_W-1:0]       bus_ad_o,
  output logic                    bus_ad_oe,
  input  logic [DATA_W-1:0]       bus_ad_i,
  output logic                    ale,
  output logic                    oe_n,
  output logic                    we_n,
  output logic [(2**CS_BITS)-1:0] cs_n,
`ifdef XBUS_READY_EN
  input  logic                    ext_ready,
`endif
  output logic [2:0]              state_dbg
);

  logic [2:0]            state;
  logic [2:0]            next_state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [CS_BITS-1:0]    cs_sel_q;
  logic                  we_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  strobe_done;
  logic                  cs_en;

  assign req_ready = (state == IDLE) && !rst;
  assign state_dbg = state;

  // STROBE ends once the wait states are spent (and the target is ready).
`ifdef XBUS_READY_EN
  assign strobe_done = (wait_cnt == '0) && ext_ready;
`else
  assign strobe_done = (wait_cnt == '0);
`endif

  // Next-state sequencing of the bus cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = ADDR;
      ADDR:    next_state = SETUP;
      SETUP:   next_state = STROBE;
      STROBE:  if (strobe_done) next_state = HOLD;
      HOLD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Chip select is registered in the decoder, so enable it from the state
  // being entered: low from SETUP through HOLD.
  assign cs_en = !rst && ((next_state == SETUP) || (next_state == STROBE) ||
                          (next_state == HOLD));

  xbus_cs_decode #(
    .CS_BITS(CS_BITS)
  ) u_cs_decode (
    .clk (clk),
    .rst (rst),
    .en  (cs_en),
    .sel (cs_sel_q),
    .cs_n(cs_n)
  );

  // State register, request latch and registered bus strobes/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      cs_sel_q  <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      bus_ad_o  <= '0;
      bus_ad_oe <= 1'b0;
      ale       <= 1'b0;
      oe_n      <= 1'b1;
      we_n      <= 1'b1;
    end else begin
      state     <= next_state;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cs_sel_q  <= req_addr[ADDR_W-1 -: CS_BITS];
            we_q      <= req_we;
            wdata_q   <= req_wdata;
            ale       <= 1'b1;
            bus_ad_o  <= req_addr;
            bus_ad_oe <= 1'b1;
          end
        end
        ADDR: begin
          ale <= 1'b0;
          if (we_q) begin
            bus_ad_o[DATA_W-1:0] <= wdata_q;
            bus_ad_oe            <= 1'b1;
          end else begin
            // Release the data pins so the target can drive them.
            bus_ad_oe <= 1'b0;
          end
        end
        SETUP: begin
          wait_cnt <= WAIT_CNT_W'(WAIT_CYC);
          oe_n     <= we_q;
          we_n     <= !we_q;
        end
        STROBE: begin
          if (strobe_done) begin
            oe_n      <= 1'b1;
            we_n      <= 1'b1;
            rsp_valid <= 1'b1;
            if (!we_q) rsp_rdata <= bus_ad_i;
          end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        HOLD: begin
          bus_ad_oe <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_master.sv
// Self-checking bench for xbus_master: a default instance, a zero-wait
// instance and a narrow-data/wide-address instance share clock and reset.
module tb_xbus_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Default instance (20/16/3, WAIT_CYC=2)
  logic        req_valid = 1'b0, req_we = 1'b0, req_ready;
  logic [19:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [19:0] bus_ad_o;
  logic        bus_ad_oe;
  logic [15:0] bus_ad_i = '0;
  logic        ale, oe_n, we_n;
  logic [7:0]  cs_n;
  logic [2:0]  state_dbg;
`ifdef XBUS_READY_EN
  logic        ext_ready = 1'b1;
`endif

  xbus_master u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .bus_ad_o(bus_ad_o),
    .bus_ad_oe(bus_ad_oe), .bus_ad_i(bus_ad_i), .ale(ale), .oe_n(oe_n),
    .we_n(we_n), .cs_n(cs_n),
`ifdef XBUS_READY_EN
    .ext_ready(ext_ready),
`endif
    .state_dbg(state_dbg)
  );

  // Zero-wait instance
  logic        z_req_valid = 1'b0, z_req_we = 1'b0, z_req_ready;
  logic [19:0] z_req_addr = '0;
  logic [15:0] z_req_wdata = '0;
  logic        z_rsp_valid;
  logic [15:0] z_rsp_rdata;
  logic [19:0] z_bus_ad_o;
  logic        z_bus_ad_oe;
  logic [15:0] z_bus_ad_i = '0;
  logic        z_ale, z_oe_n, z_we_n;
  logic [7:0]  z_cs_n;
  logic [2:0]  z_state_dbg;

  xbus_master #(.WAIT_CYC(0)) u_dut_z (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_we(z_req_we), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .bus_ad_o(z_bus_ad_o),
    .bus_ad_oe(z_bus_ad_oe), .bus_ad_i(z_bus_ad_i), .ale(z_ale), .oe_n(z_oe_n),
    .we_n(z_we_n), .cs_n(z_cs_n),
`ifdef XBUS_READY_EN
    .ext_ready(1'b1),
`endif
    .state_dbg(z_state_dbg)
  );

  // Width-scaled instance (24/8/2)
  logic        w_req_valid = 1'b0, w_req_we = 1'b0, w_req_ready;
  logic [23:0] w_req_addr = '0;
  logic [7:0]  w_req_wdata = '0;
  logic        w_rsp_valid;
  logic [7:0]  w_rsp_rdata;
  logic [23:0] w_bus_ad_o;
  logic        w_bus_ad_oe;
  logic [7:0]  w_bus_ad_i = '0;
  logic        w_ale, w_oe_n, w_we_n;
  logic [3:0]  w_cs_n;
  logic [2:0]  w_state_dbg;

  xbus_master #(.ADDR_W(24), .DATA_W(8), .CS_BITS(2)) u_dut_w (
    .clk(clk), .rst(rst), .req_valid(w_req_valid), .req_ready(w_req_ready),
    .req_we(w_req_we), .req_addr(w_req_addr), .req_wdata(w_req_wdata),
    .rsp_valid(w_rsp_valid), .rsp_rdata(w_rsp_rdata), .bus_ad_o(w_bus_ad_o),
    .bus_ad_oe(w_bus_ad_oe), .bus_ad_i(w_bus_ad_i), .ale(w_ale), .oe_n(w_oe_n),
    .we_n(w_we_n), .cs_n(w_cs_n),
`ifdef XBUS_READY_EN
    .ext_ready(1'b1),
`endif
    .state_dbg(w_state_dbg)
  );

  // Scoreboards: expected rsp_rdata per response ({is_write, data})
  logic [16:0] exp_q[$];
  logic [15:0] z_exp_q[$];
  logic [15:0] model_rdata = '0;

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: rsp_valid=1 with no outstanding request");
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if (rsp_rdata !== e[15:0]) begin
          errors++;
          $display("FAIL rsp_rdata(we=%0b): got %h expected %h", e[16], rsp_rdata, e[15:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (z_rsp_valid === 1'b1) begin
      checks++;
      if (z_exp_q.size() == 0) begin
        errors++;
        $display("FAIL z_rsp_unexpected: rsp_valid=1 with no outstanding request");
      end else begin
        logic [15:0] e;
        e = z_exp_q.pop_front();
        if (z_rsp_rdata !== e) begin
          errors++;
          $display("FAIL z_rsp_rdata: got %h expected %h", z_rsp_rdata, e);
        end
      end
    end
  end

  // Driver: wait (bounded) for req_ready, present one request, then
  // scramble req_* after the acceptance edge. Returns at acceptance+1.
  task automatic main_send(input logic we, input logic [19:0] addr, input logic [15:0] wdata);
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL main_ready_wait: req_ready=%b expected 1", req_ready);
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = 20'($urandom_range(0, 20'hFFFFF));
    req_wdata = 16'($urandom_range(0, 16'hFFFF));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: req_ready=%b expected 0", req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ale, oe_n, we_n, bus_ad_oe, rsp_valid, req_ready} !== 6'b011001 ||
        cs_n !== 8'hFF || bus_ad_o !== 20'h0 || rsp_rdata !== 16'h0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: ale=%b oe_n=%b we_n=%b oe=%b rsp=%b rdy=%b cs_n=%h ad=%h rd=%h st=%0d expected 0 1 1 0 0 1 ff 0 0 0",
               ale, oe_n, we_n, bus_ad_oe, rsp_valid, req_ready, cs_n, bus_ad_o, rsp_rdata, state_dbg);
    end
    // Write interrupted by reset in its first STROBE cycle
    main_send(1'b1, 20'h4_0010, 16'h1234);
    repeat (3) @(negedge clk);
    checks++;
    if (we_n !== 1'b0 || state_dbg !== 3'd3) begin
      errors++;
      $display("FAIL reset_pre_strobe: we_n=%b state=%0d expected 0 3", we_n, state_dbg);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (we_n !== 1'b1 || oe_n !== 1'b1 || ale !== 1'b0 || cs_n !== 8'hFF ||
        bus_ad_oe !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_op: we_n=%b oe_n=%b ale=%b cs_n=%h oe=%b rsp=%b expected 1 1 0 ff 0 0",
               we_n, oe_n, ale, cs_n, bus_ad_oe, rsp_valid);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_rsp: rsp_valid=%b expected 0", rsp_valid);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: req_ready=%b state=%0d expected 1 0", req_ready, state_dbg);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_read();
    int ale_cnt = 0, oe_cnt = 0, we_cnt = 0, rsp_at = -1;
    bit cs_bad = 0, excl_bad = 0, addr_bad = 0, turn_bad = 0;
    exp_q.push_back({1'b0, 16'hBEEF});
    model_rdata = 16'hBEEF;
    bus_ad_i = 16'hBEEF ^ 16'($urandom_range(1, 16'hFFFF));
    main_send(1'b0, 20'h0_00A5, 16'($urandom_range(0, 16'hFFFF)));
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ale) ale_cnt++;
      if (!oe_n) oe_cnt++;
      if (!we_n) we_cnt++;
      if (rsp_valid) rsp_at = i;
      if ((ale && (!oe_n || !we_n)) || (!oe_n && !we_n)) excl_bad = 1;
      if (cs_n !== ((i >= 2 && i <= 6) ? 8'hFE : 8'hFF)) cs_bad = 1;
      if (i == 1 && (bus_ad_o !== 20'h0_00A5 || bus_ad_oe !== 1'b1)) addr_bad = 1;
      if (i == 2 && bus_ad_oe !== 1'b0) turn_bad = 1;
      // Only the value present at the final STROBE edge is valid data.
      bus_ad_i = (i == 5) ? 16'hBEEF : 16'hBEEF ^ 16'($urandom_range(1, 16'hFFFF));
    end
    checks += 7;
    if (ale_cnt != 1) begin errors++; $display("FAIL read_ale_len: got %0d expected 1", ale_cnt); end
    if (oe_cnt != 3 || we_cnt != 0) begin
      errors++; $display("FAIL read_strobe_len: oe_low=%0d we_low=%0d expected 3 0", oe_cnt, we_cnt);
    end
    if (rsp_at != 6) begin errors++; $display("FAIL read_latency: rsp at +%0d expected +6", rsp_at); end
    if (cs_bad) begin errors++; $display("FAIL read_cs_n: window wrong, expected fe for SETUP..HOLD"); end
    if (excl_bad) begin errors++; $display("FAIL read_strobe_overlap: strobes overlapped, expected none"); end
    if (addr_bad || turn_bad) begin
      errors++; $display("FAIL read_addr_phase: addr_bad=%0b turn_bad=%0b expected 0 0", addr_bad, turn_bad);
    end
    if (rsp_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL read_rdata_hold: got %h expected beef", rsp_rdata);
    end
  endtask

  task automatic test_write();
    int oe_cnt = 0, we_cnt = 0, rsp_at = -1;
    bit cs_bad = 0, drive_bad = 0, addr_bad = 0;
    exp_q.push_back({1'b1, model_rdata});
    main_send(1'b1, 20'hE_1234, 16'h55AA);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (!oe_n) oe_cnt++;
      if (!we_n) we_cnt++;
      if (rsp_valid) rsp_at = i;
      if (cs_n !== ((i >= 2 && i <= 6) ? 8'h7F : 8'hFF)) cs_bad = 1;
      if (i == 1 && (bus_ad_o !== 20'hE_1234 || ale !== 1'b1)) addr_bad = 1;
      if (i >= 2 && i <= 6 && (bus_ad_oe !== 1'b1 || bus_ad_o[15:0] !== 16'h55AA)) drive_bad = 1;
      if (i == 7 && bus_ad_oe !== 1'b0) drive_bad = 1;
    end
    checks += 5;
    if (we_cnt != 3 || oe_cnt != 0) begin
      errors++; $display("FAIL write_strobe_len: we_low=%0d oe_low=%0d expected 3 0", we_cnt, oe_cnt);
    end
    if (rsp_at != 6) begin errors++; $display("FAIL write_latency: rsp at +%0d expected +6", rsp_at); end
    if (cs_bad) begin errors++; $display("FAIL write_cs_n: window wrong, expected 7f for SETUP..HOLD"); end
    if (addr_bad) begin errors++; $display("FAIL write_addr_phase: address phase wrong, expected e1234 with ale"); end
    if (drive_bad) begin
      errors++; $display("FAIL write_data_drive: data/oe wrong, expected 55aa driven SETUP..HOLD only");
    end
  endtask

`ifdef XBUS_READY_EN
  task automatic test_ready_ext();
    int oe_cnt = 0, rsp_at = -1;
    exp_q.push_back({1'b0, 16'h1009});
    model_rdata = 16'h1009;
    ext_ready = 1'b1;
    bus_ad_i  = 16'h1000;
    main_send(1'b0, 20'h2_0040, 16'h0);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (!oe_n) oe_cnt++;
      if (rsp_valid) rsp_at = i;
      bus_ad_i  = 16'h1000 + 16'(i);
      ext_ready = (i < 5) || (i >= 9);
    end
    ext_ready = 1'b1;
    checks += 2;
    if (oe_cnt != 7) begin errors++; $display("FAIL ready_oe_len: got %0d expected 7", oe_cnt); end
    if (rsp_at != 10) begin errors++; $display("FAIL ready_latency: rsp at +%0d expected +10", rsp_at); end
  endtask
`endif

  task automatic test_back_to_back();
    logic [15:0] d1, d2;
    int acc2 = -1, rsp1 = -1, rsp2 = -1;
    bit oe_bad = 0, cs_bad = 0;
    d1 = 16'($urandom_range(0, 16'hFFFF));
    d2 = 16'($urandom_range(0, 16'hFFFF));
    z_exp_q.push_back(d1);
    z_exp_q.push_back(d2);
    @(negedge clk);
    checks++;
    if (z_req_ready !== 1'b1) begin
      errors++; $display("FAIL z_ready_idle: req_ready=%b expected 1", z_req_ready);
    end
    z_req_valid = 1'b1;
    z_req_we    = 1'b0;
    z_req_addr  = 20'h2_0000 | 20'($urandom_range(0, 16'hFFFF));
    z_bus_ad_i  = d1;
    @(posedge clk);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if ((z_oe_n === 1'b0) != (i == 3 || i == 8)) oe_bad = 1;
      if (i == 2 && z_cs_n !== 8'hFD) cs_bad = 1;
      if (i == 7 && z_cs_n !== 8'hF7) cs_bad = 1;
      if (z_rsp_valid) begin
        if (rsp1 < 0) rsp1 = i; else rsp2 = i;
      end
      if (i == 1) z_req_addr = 20'h6_0000 | 20'($urandom_range(0, 16'hFFFF));
      if (i == 4) z_bus_ad_i = d2;
      if (acc2 >= 0) z_req_valid = 1'b0;
      if (acc2 < 0 && z_req_ready === 1'b1 && z_req_valid) acc2 = i;
    end
    z_req_valid = 1'b0;
    checks += 4;
    if (acc2 != 5) begin errors++; $display("FAIL z_second_accept: at +%0d expected +5", acc2); end
    if (rsp1 != 4 || rsp2 != 9) begin
      errors++; $display("FAIL z_latency: rsp at +%0d/+%0d expected +4/+9", rsp1, rsp2);
    end
    if (oe_bad) begin errors++; $display("FAIL z_oe_pulses: oe_n pattern wrong, expected low only at +3 and +8"); end
    if (cs_bad) begin errors++; $display("FAIL z_cs_n: select wrong, expected fd then f7"); end
  endtask

  task automatic test_width();
    logic [7:0] d;
    int rsp_at = -1;
    bit addr_bad = 0, turn_bad = 0, wr_bad = 0;
    d = 8'($urandom_range(0, 255));
    @(negedge clk);
    checks++;
    if (w_req_ready !== 1'b1) begin
      errors++; $display("FAIL w_ready_idle: req_ready=%b expected 1", w_req_ready);
    end
    w_req_valid = 1'b1; w_req_we = 1'b0; w_req_addr = 24'hC0_0001; w_bus_ad_i = ~d;
    @(posedge clk);
    #1 w_req_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1 && (w_bus_ad_o !== 24'hC0_0001 || w_bus_ad_oe !== 1'b1 || w_ale !== 1'b1)) addr_bad = 1;
      if (i == 2 && (w_cs_n !== 4'b0111 || w_bus_ad_oe !== 1'b0 || w_bus_ad_o[23:8] !== 16'hC000)) turn_bad = 1;
      if (w_rsp_valid) rsp_at = i;
      w_bus_ad_i = (i == 5) ? d : ~d;
    end
    // Write: only the low 8 pins take data, upper address bits stay put.
    w_req_valid = 1'b1; w_req_we = 1'b1; w_req_addr = 24'h40_00FF; w_req_wdata = 8'h3C;
    @(posedge clk);
    #1 w_req_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 2 && (w_bus_ad_o !== 24'h40_003C || w_bus_ad_oe !== 1'b1 || w_cs_n !== 4'b1101)) wr_bad = 1;
    end
    checks += 5;
    if (addr_bad) begin errors++; $display("FAIL w_addr_phase: expected c00001 on all 24 bits with ale"); end
    if (turn_bad) begin errors++; $display("FAIL w_turnaround: cs_n=%b oe=%b expected 0111 0", w_cs_n, w_bus_ad_oe); end
    if (rsp_at != 6) begin errors++; $display("FAIL w_latency: rsp at +%0d expected +6", rsp_at); end
    if (w_rsp_rdata !== d) begin errors++; $display("FAIL w_rdata: got %h expected %h", w_rsp_rdata, d); end
    if (wr_bad) begin errors++; $display("FAIL w_write_drive: expected 40003c driven, cs_n 1101"); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
`ifdef XBUS_READY_EN
    test_ready_ext();
`endif
    test_back_to_back();
    test_width();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || z_exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d/%0d responses missing, expected 0/0", exp_q.size(), z_exp_q.size());
    end
    checks++;
    if (state_dbg !== 3'd0 || z_state_dbg !== 3'd0 || w_state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL final_idle: states %0d %0d %0d expected 0 0 0", state_dbg, z_state_dbg, w_state_dbg);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
